// File: rtl/dmem_mmio_bus.sv
// Data-side memory for the single-cycle core: word RAM, a free-running cycle
// counter and a console TX FIFO behind a small MMIO window, with combinational reads.
module dmem_mmio_bus #(
  parameter int          RAM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {R_TXDATA, R_TXSTAT, R_CYCLES, R_DROPS} reg_e;

  logic [31:0]   ram [RAM_WORDS];
  logic [7:0]    fifo [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   cycles, drops, txstat;

  logic is_ram, is_mmio, full, empty, pop, push_req, push_ok, drop;
  logic wr_cycles, wr_drops;
  reg_e off;

  // The MMIO window is 16 bytes, so addr[3:2] alone picks the register.
  assign is_ram  = addr < 32'(RAM_WORDS * 4);
  assign is_mmio = addr[31:4] == MMIO_BASE[31:4];
  assign off     = reg_e'(addr[3:2]);

  assign full     = count == CW'(FIFO_DEPTH);
  assign empty    = count == '0;
  assign tx_valid = !empty;
  assign tx_data  = tx_valid ? fifo[rd_ptr] : 8'h00;
  assign pop      = tx_valid && tx_ready;

  assign push_req  = memwrite && is_mmio && off == R_TXDATA;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok   = push_req && (!full || pop);
  assign drop      = push_req && !push_ok;
  assign wr_cycles = memwrite && is_mmio && off == R_CYCLES;
  assign wr_drops  = memwrite && is_mmio && off == R_DROPS;

  always_comb begin
    txstat         = '0;
    txstat[0]      = full;
    txstat[1]      = empty;
    txstat[8 +: CW] = count;
  end

  always_comb begin
    readdata = '0;
    if (is_ram) readdata = ram[addr[AW+1:2]];
    else if (is_mmio) begin
      case (off)
        R_TXSTAT: readdata = txstat;
        R_CYCLES: readdata = cycles;
        R_DROPS:  readdata = drops;
        default:  readdata = '0;
      endcase
    end
  end

  // Storage arrays carry no reset; only their write enables are gated by it.
  always_ff @(posedge clk) begin
    if (!reset && memwrite && is_ram) ram[addr[AW+1:2]] <= writedata;
    if (!reset && push_ok)            fifo[wr_ptr]      <= writedata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      cycles <= '0;
      drops  <= '0;
    end else begin
      cycles <= wr_cycles ? writedata : cycles + 32'd1;
      if (wr_drops)  drops <= writedata;
      else if (drop) drops <= drops + 32'd1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
    end
  end
endmodule
